pipeline_control: RTL

Sequencing and hazard controller for the four-stage fetch/decode/execute/writeback datapath. Owns the program counter, clears the register file after reset, and starts and halts execution on request. Detects read-after-write hazards between the instruction in decode and the instructions in execute/writeback. Resolves each hazard by holding fetch and inserting a bubble, since the datapath has no forwarding and the register file has no write-through.

---
 rtl/pipeline_pkg.sv | 33 +++
 rtl/hazard_detect.sv | 32 +++
 rtl/pipeline_control.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared definitions for the four-stage pipeline controller:
//   - state_t     : FSM state encoding, also the value seen on `state`
//   - REG_ADDR_W  : register-address width
//   - REG_ZERO    : the hard-wired zero register, which never causes a hazard
//   - src_match() : true when a decode source reads a pending destination
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RF_CLEAR = 2'd0,
    ST_IDLE     = 2'd1,
    ST_RUN      = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;

  // A pending write to x0 is discarded by the register file, so a source of
  // x0 never has to wait for it.
  function automatic logic src_match(input reg_addr_t rs1,
                                     input reg_addr_t rs2,
                                     input reg_addr_t dest,
                                     input logic      write_enable);
    return write_enable && (dest != REG_ZERO) && ((rs1 == dest) || (rs2 == dest));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
//   Combinational read-after-write comparator. Reports, per later stage,
//   whether the instruction in decode reads a register that stage will write.
//   Kept separate so a forwarding unit can reuse the per-stage matches.
//
//   Ports
//     rs1, rs2         in  source registers of the instruction in decode
//     ex_reg_dest      in  destination of the instruction in execute
//     ex_write_enable  in  execute will write ex_reg_dest
//     wb_reg_dest      in  destination of the instruction in writeback
//     wb_write_enable  in  writeback will write wb_reg_dest
//     match_ex         out decode reads what execute writes
//     match_wb         out decode reads what writeback writes
// -----------------------------------------------------------------------------
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] ex_reg_dest,
  input  logic                  ex_write_enable,
  input  logic [REG_ADDR_W-1:0] wb_reg_dest,
  input  logic                  wb_write_enable,
  output logic                  match_ex,
  output logic                  match_wb
);

  assign match_ex = src_match(rs1, rs2, ex_reg_dest, ex_write_enable);
  assign match_wb = src_match(rs1, rs2, wb_reg_dest, wb_write_enable);

endmodule

// File: rtl/pipeline_control.sv
// -----------------------------------------------------------------------------
// pipeline_control
//   Sequencer and hazard controller for the fetch/decode/execute/writeback
//   datapath. Clears the register file after reset, starts and halts
//   execution, owns the program counter and stalls decode on RAW hazards
//   (the datapath has no forwarding and the register file no write-through).
//
//   Parameters
//     PC_WIDTH         width of pc and of both performance counters
//     RF_CLEAR_CYCLES  cycles reset_rf_n stays low after reset falls (>= 1)
//     DRAIN_CYCLES     bubble cycles issued after a halt (>= 1)
//
//   Ports
//     clock            in  rising-edge clock
//     reset            in  synchronous, active-high
//     start            in  level; leave IDLE and run (ignored elsewhere)
//     halt_req         in  level; stop fetching and drain (RUN only)
//     dec_valid        in  decode holds a real instruction
//     rs1, rs2         in  decode source registers
//     ex_reg_dest/ex_write_enable  in  pending write in execute
//     wb_reg_dest/wb_write_enable  in  pending write in writeback
//     pc               out registered fetch address (word index)
//     inst_enable      out fetch instruction-register enable
//     bubble           out forces the decoded write_enable to 0
//     reset_rf_n       out active-low register-file clear
//     state            out current FSM state (state_t encoding)
//     retired_count    out saturating count of writeback writes
//     stall_count      out saturating count of hazard stall cycles
// -----------------------------------------------------------------------------
module pipeline_control
  import pipeline_pkg::*;
#(
  parameter int PC_WIDTH        = 32,
  parameter int RF_CLEAR_CYCLES = 2,
  parameter int DRAIN_CYCLES    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] ex_reg_dest,
  input  logic                  ex_write_enable,
  input  logic [REG_ADDR_W-1:0] wb_reg_dest,
  input  logic                  wb_write_enable,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  inst_enable,
  output logic                  bubble,
  output logic                  reset_rf_n,
  output logic [1:0]            state,
  output logic [PC_WIDTH-1:0]   retired_count,
  output logic [PC_WIDTH-1:0]   stall_count
);

  // One down-counter times both the register-file clear and the drain, so
  // it is sized for the longer of the two.
  localparam int CNT_MAX = (RF_CLEAR_CYCLES > DRAIN_CYCLES) ? RF_CLEAR_CYCLES
                                                            : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The counter is loaded with N-1 and the state exits when it reads 0, so
  // the state lasts exactly N cycles.
  localparam logic [CNT_W-1:0]    RF_LOAD    = CNT_W'(RF_CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0]    DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [PC_WIDTH-1:0] PC_ONE     = PC_WIDTH'(1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             match_ex;
  logic             match_wb;
  logic             hazard;
  logic             pc_advance;
  logic             stall;

  hazard_detect u_hazard_detect (
    .rs1             (rs1),
    .rs2             (rs2),
    .ex_reg_dest     (ex_reg_dest),
    .ex_write_enable (ex_write_enable),
    .wb_reg_dest     (wb_reg_dest),
    .wb_write_enable (wb_write_enable),
    .match_ex        (match_ex),
    .match_wb        (match_wb)
  );

  assign hazard = dec_valid & (match_ex | match_wb);

  // ---------------------------------------------------------------------------
  // Next state and per-cycle controls
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    inst_enable = 1'b0;
    bubble      = 1'b1;
    pc_advance  = 1'b0;
    stall       = 1'b0;

    unique case (state_q)
      ST_RF_CLEAR: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end

      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end

      ST_RUN: begin
        // A stall cycle is counted even when a halt wins the same cycle.
        stall = hazard;
        if (halt_req) begin
          // Fetch is held on the halt cycle so pc still points at the first
          // unfetched instruction when execution resumes.
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else if (!hazard) begin
          inst_enable = 1'b1;
          bubble      = 1'b0;
          pc_advance  = 1'b1;
        end
      end

      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
    endcase
  end

  assign reset_rf_n = (state_q != ST_RF_CLEAR);
  assign state      = state_q;

  // ---------------------------------------------------------------------------
  // State, counter, pc and performance counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // The clear counter is reloaded on every reset cycle, so a long reset
      // still gives a full-length clear after it falls.
      state_q       <= ST_RF_CLEAR;
      cnt_q         <= RF_LOAD;
      pc            <= '0;
      retired_count <= '0;
      stall_count   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_advance) pc <= pc + PC_ONE;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + PC_ONE;
      if (wb_write_enable && (retired_count != '1))
        retired_count <= retired_count + PC_ONE;
    end
  end

endmodule
